// File: rtl/fp_mont_alu.sv
// fp_mont_alu: prime-field arithmetic responder for the SM9 scalar-mult datapath.
//   - bit-serial radix-2 Montgomery product (R = 2^256) on data_mm, end_mm strobe
//   - combinational modular subtract (and optionally add) on data_as
// Optional feature macro: FP_MODADD_EN -- when defined, select 3'b001 performs a
// modular add on data_as; when undefined the adder is absent and 3'b001 yields 0.
//
// Request/response protocol (select / end_mm):
//   A multiply is requested by holding select == 3'b100 while the multiplier is
//   IDLE; operands are captured on that edge and are not looked at again until
//   the next capture. end_mm is high for exactly one cycle, 257 cycles after the
//   capture edge, with data_mm valid from that edge and held until the next
//   completion. Two further cycles (DONE, GAP) pass before a new capture can
//   happen, giving the initiator time to load fresh operands. There is no
//   backpressure: select changes outside IDLE are ignored and never abort.
module fp_mont_alu #(
   parameter logic [255:0] P_MOD =
      256'hB640000002A3A6F1D603AB4FF58EC74521F2934B1A7AEEDBE56F9B27E351457D
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic [2:0]   select,
   input  logic [255:0] data_ina,
   input  logic [255:0] data_inb,
   output logic [255:0] data_mm,
   output logic         end_mm,
   output logic [255:0] data_as,
   output logic [2:0]   dbg_state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN  = 3'd1,
      FIN  = 3'd2,
      DONE = 3'd3,
      GAP  = 3'd4
   } state_t;

   localparam logic [2:0]   SEL_MM  = 3'b100;
   localparam logic [2:0]   SEL_SUB = 3'b010;
   localparam logic [2:0]   SEL_ADD = 3'b001;
   localparam logic [257:0] P_EXT   = {2'b00, P_MOD};

   state_t         r_state;
   state_t         w_state_nxt;
   logic           w_start;

   logic [255:0]   r_a;
   logic [255:0]   r_b;
   logic [257:0]   r_t;
   logic [7:0]     r_i;
   logic [255:0]   r_data_mm;
   logic           r_end_mm;

   logic [257:0]   w_t_add;
   logic [257:0]   w_t_odd;
   logic [257:0]   w_t_shr;
   logic [255:0]   w_t_red;

   logic [255:0]   w_sub;
`ifdef FP_MODADD_EN
   logic [256:0]   w_sum;
   logic [255:0]   w_add;
`endif

   // One Montgomery iteration: add A[i]*B, make T even by adding P, halve.
   // T stays below 2P after the shift, so 258 bits never overflow.
   assign w_t_add = r_t + (r_a[r_i] ? {2'b00, r_b} : 258'd0);
   assign w_t_odd = w_t_add + (w_t_add[0] ? P_EXT : 258'd0);
   assign w_t_shr = w_t_odd >> 1;

   // Final conditional subtraction; T < 2P so one subtraction fully reduces.
   assign w_t_red = (r_t >= P_EXT) ? (r_t[255:0] - P_MOD) : r_t[255:0];

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; DONE and GAP give the initiator a two-cycle turnaround.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         IDLE: begin
            if (select == SEL_MM) begin
               w_start     = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (r_i == 8'd255) begin
               w_state_nxt = FIN;
            end
         end
         FIN:     w_state_nxt = DONE;
         DONE:    w_state_nxt = GAP;
         GAP:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture, iteration datapath, result and completion strobe.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_a       <= '0;
         r_b       <= '0;
         r_t       <= '0;
         r_i       <= '0;
         r_data_mm <= '0;
         r_end_mm  <= 1'b0;
      end else begin
         r_end_mm <= (r_state == FIN);
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_a <= data_ina;
                  r_b <= data_inb;
                  r_t <= '0;
                  r_i <= '0;
               end
            end
            RUN: begin
               r_t <= w_t_shr;
               r_i <= r_i + 8'd1;
            end
            FIN: begin
               r_data_mm <= w_t_red;
            end
            default: begin
            end
         endcase
      end
   end

   // Subtract: a borrow is repaired by adding P; the low 256 bits of
   // (a - b + P) equal the modulo-2^256 sum of the same terms.
   assign w_sub = data_ina - data_inb + ((data_ina >= data_inb) ? 256'd0 : P_MOD);

`ifdef FP_MODADD_EN
   // Add: 257-bit sum, one conditional subtraction of P.
   assign w_sum = {1'b0, data_ina} + {1'b0, data_inb};
   assign w_add = (w_sum >= {1'b0, P_MOD}) ? (w_sum[255:0] - P_MOD) : w_sum[255:0];
`endif

   // Add/subtract result mux, independent of the multiplier state.
   always_comb begin
      data_as = 256'd0;
      case (select)
         SEL_SUB: data_as = w_sub;
`ifdef FP_MODADD_EN
         SEL_ADD: data_as = w_add;
`endif
         default: data_as = 256'd0;
      endcase
   end

   assign data_mm   = r_data_mm;
   assign end_mm    = r_end_mm;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_mont_alu.sv
// tb_fp_mont_alu: directed checks of fp_mont_alu -- reset state, Montgomery
// products and latency, add/sub vectors, back-to-back chaining with an
// initiator model, mid-run disturbance and mid-run reset.
// Honours FP_MODADD_EN for the expected value of select 3'b001.
module tb_fp_mont_alu;

   localparam logic [255:0] P    = 256'hB640000002A3A6F1D603AB4FF58EC74521F2934B1A7AEEDBE56F9B27E351457D;
   localparam logic [255:0] R2   = 256'h2EA795A656F62FBDE479B522D6706E7B88F8105FAE1A5D3F27DEA312B417E2D2;
   localparam logic [255:0] RMOD = 256'h49BFFFFFFD5C590E29FC54B00A7138BADE0D6CB4E58511241A9064D81CAEBA83;

   logic         clk;
   logic         rst_b;
   logic [2:0]   select;
   logic [255:0] data_ina;
   logic [255:0] data_inb;
   logic [255:0] data_mm;
   logic         end_mm;
   logic [255:0] data_as;
   logic [2:0]   dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   fp_mont_alu dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .select    (select),
      .data_ina  (data_ina),
      .data_inb  (data_inb),
      .data_mm   (data_mm),
      .end_mm    (end_mm),
      .data_as   (data_as),
      .dbg_state (dbg_state)
   );

   // Clock and free-running cycle counter.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: (a*b mod P) via a wide remainder, then 256 modular halvings.
   function automatic logic [255:0] mont_model(input logic [255:0] a, input logic [255:0] b);
      logic [511:0] prod;
      logic [511:0] p_wide;
      logic [256:0] x;
      prod   = {256'd0, a} * {256'd0, b};
      p_wide = {256'd0, P};
      prod   = prod % p_wide;
      x      = {1'b0, prod[255:0]};
      for (int k = 0; k < 256; k++) begin
         if (x[0]) x = (x + {1'b0, P}) >> 1;
         else      x = x >> 1;
      end
      return x[255:0];
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Wait for end_mm with a cycle budget; ok=0 if it never came.
   task automatic wait_end(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         #1;
         if (end_mm) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Single multiply from IDLE: checks latency, result and one-cycle strobe.
   task automatic do_mm(input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] exp, input string tag);
      bit ok;
      int cap;
      select = 3'b000;
      repeat (4) @(posedge clk);
      #1;
      data_ina = a;
      data_inb = b;
      select   = 3'b100;
      @(posedge clk);
      #1;
      cap    = cyc;
      select = 3'b000;
      wait_end(300, ok);
      chk_int({tag, "_end_seen"}, int'(ok), 1);
      chk_int({tag, "_latency"}, cyc - cap, 257);
      chk({tag, "_data_mm"}, data_mm, exp);
      @(posedge clk);
      #1;
      chk({tag, "_end_one_cycle"}, {255'd0, end_mm}, 256'd0);
      chk({tag, "_data_hold"}, data_mm, exp);
   endtask

   initial begin
      bit           ok;
      int           cap;
      int           pulses;
      int           t_end [3];
      logic [255:0] chain_exp [3];
      logic [255:0] chain_next [3];

      // Reset, with a multiply request present that must be ignored.
      rst_b    = 1'b0;
      select   = 3'b100;
      data_ina = R2;
      data_inb = 256'd1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data_mm", data_mm, 256'd0);
      chk("reset_end_mm", {255'd0, end_mm}, 256'd0);
      chk("reset_state", {253'd0, dbg_state}, 256'd0);
      select = 3'b000;
      rst_b  = 1'b1;

      // Montgomery products.
      do_mm(R2, 256'd1, RMOD, "r_mod_p");
      do_mm(RMOD, 256'd1, 256'd1, "identity_one");
      do_mm(256'd0, 256'd1, 256'd0, "identity_zero");
      do_mm(R2, R2, mont_model(R2, R2), "r2_sq");
      do_mm(P - 256'd1, P - 256'd1, mont_model(256'd1, 256'd1), "pm1_sq");

      // Add/subtract vectors.
      select = 3'b010; data_ina = 256'd1; data_inb = 256'd2; #1;
      chk("sub_borrow", data_as, P - 256'd1);
      select = 3'b010; data_ina = 256'd5; data_inb = 256'd3; #1;
      chk("sub_plain", data_as, 256'd2);
      select = 3'b010; data_ina = RMOD; data_inb = RMOD; #1;
      chk("sub_equal", data_as, 256'd0);
      select = 3'b001; data_ina = P - 256'd1; data_inb = 256'd2; #1;
`ifdef FP_MODADD_EN
      chk("add_wrap", data_as, 256'd1);
`else
      chk("add_disabled", data_as, 256'd0);
`endif
      select = 3'b001; data_ina = 256'd3; data_inb = 256'd4; #1;
`ifdef FP_MODADD_EN
      chk("add_plain", data_as, 256'd7);
`else
      chk("add_disabled_2", data_as, 256'd0);
`endif
      select = 3'b000; #1;
      chk("sel_none", data_as, 256'd0);
      select = 3'b111; #1;
      chk("sel_undef", data_as, 256'd0);
      select = 3'b000;

      // Back-to-back: select held at 100, A rewritten the cycle after end_mm.
      chain_exp[0]  = RMOD;
      chain_exp[1]  = 256'd1;
      chain_exp[2]  = mont_model(256'd1, 256'd1);
      chain_next[0] = RMOD;
      chain_next[1] = 256'd1;
      chain_next[2] = 256'd0;
      repeat (4) @(posedge clk);
      #1;
      data_ina = R2;
      data_inb = 256'd1;
      select   = 3'b100;
      for (int k = 0; k < 3; k++) begin
         wait_end(600, ok);
         chk_int($sformatf("b2b_end_seen_%0d", k), int'(ok), 1);
         t_end[k] = cyc;
         chk($sformatf("b2b_data_%0d", k), data_mm, chain_exp[k]);
         @(posedge clk);
         #1;
         chk($sformatf("b2b_end_one_cycle_%0d", k), {255'd0, end_mm}, 256'd0);
         data_ina = chain_next[k];
      end
      select = 3'b000;
      chk_int("b2b_spacing_01", t_end[1] - t_end[0], 260);
      chk_int("b2b_spacing_12", t_end[2] - t_end[1], 260);

      // Mid-run disturbance: operands and select change at RUN cycle 100.
      repeat (4) @(posedge clk);
      #1;
      data_ina = R2;
      data_inb = 256'd1;
      select   = 3'b100;
      @(posedge clk);
      #1;
      cap = cyc;
      repeat (100) @(posedge clk);
      #1;
      data_ina = 256'd5;
      data_inb = 256'd3;
      select   = 3'b010;
      #1;
      chk("overlap_sub", data_as, 256'd2);
      wait_end(300, ok);
      chk_int("disturb_end_seen", int'(ok), 1);
      chk_int("disturb_latency", cyc - cap, 257);
      chk("disturb_data_mm", data_mm, RMOD);
      select = 3'b000;

      // Reset at RUN cycle 150 aborts with no strobe; data_mm cleared.
      repeat (4) @(posedge clk);
      #1;
      data_ina = R2;
      data_inb = 256'd1;
      select   = 3'b100;
      @(posedge clk);
      #1;
      select = 3'b000;
      repeat (150) @(posedge clk);
      #1;
      rst_b = 1'b0;
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      chk("midreset_data_mm", data_mm, 256'd0);
      chk("midreset_state", {253'd0, dbg_state}, 256'd0);
      pulses = 0;
      repeat (300) begin
         @(posedge clk);
         #1;
         if (end_mm) pulses++;
      end
      chk_int("midreset_no_end", pulses, 0);
      do_mm(RMOD, 256'd1, 256'd1, "after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
